// File: rtl/fft_sdf_stage_tw_ctrl_if.sv
// Handshake and datapath-control bundle between an SDF stage sequencer and its
// upstream stream source / butterfly, delay-line and twiddle datapath.
interface fft_sdf_stage_tw_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic              in_valid;
   logic              in_ready;
   logic              flush_req;
   logic              sel_bf;
   logic              stage_valid;
   logic [ADDR_W-1:0] tw_addr;
   logic              tw_en;
   logic              tw_valid;
   logic              tw_trivial;
   logic              frame_last;
   logic              busy;

   modport master (
      output in_valid, flush_req,
      input  in_ready, sel_bf, stage_valid, tw_addr, tw_en, tw_valid,
             tw_trivial, frame_last, busy
   );

   modport slave (
      input  in_valid, flush_req,
      output in_ready, sel_bf, stage_valid, tw_addr, tw_en, tw_valid,
             tw_trivial, frame_last, busy
   );
endinterface

// File: rtl/fft_sdf_stage_tw_ctrl.sv
// Radix-2 SDF stage sequencer: phase select, twiddle ROM addressing and end-of-stream drain.
// Optional macro TW_ROM_PWR_SAVE_EN gates tw_en off for butterfly-half and index-0 twiddles.
module fft_sdf_stage_tw_ctrl #(
   parameter int N      = 256,
   parameter int SIZE   = 8,
   parameter int STAGE  = 4,
   parameter int ADDR_W = SIZE - 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fft_sdf_stage_tw_ctrl_if.slave bus
);
   localparam int D = N >> STAGE;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]        state;
   logic [SIZE-1:0]   cnt;
   logic              pending;
   logic              flush_pend;

   logic [SIZE-1:0]   k;
   logic [SIZE-1:0]   k_lo;
   logic              at_boundary;
   logic              in_ready;
   logic              accept;
   logic              pseudo;
   logic              issue;
   logic              last_pseudo;
   logic              sel_bf_nxt;
   logic [ADDR_W-1:0] tw_addr_nxt;
   logic              tw_en_nxt;

   logic              sel_bf_q;
   logic              stage_valid_q;
   logic [ADDR_W-1:0] tw_addr_q;
   logic              tw_en_q;
   logic              tw_valid_q;
   logic              tw_trivial_q;
   logic              frame_last_q;

   assign k           = cnt & SIZE'(2 * D - 1);
   assign k_lo        = cnt & SIZE'(D - 1);
   assign at_boundary = flush_pend && (k == '0);

   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_IDLE:  in_ready = 1'b1;
         S_RUN:   in_ready = !at_boundary;
         default: in_ready = 1'b0;
      endcase
   end

   // FLUSH issues one pseudo-sample per cycle; it shares the accept path's outputs.
   assign accept      = bus.in_valid && in_ready;
   assign pseudo      = (state == S_FLUSH);
   assign issue       = accept || pseudo;
   assign last_pseudo = pseudo && (k == SIZE'(D - 1));
   assign sel_bf_nxt  = accept && cnt[SIZE-STAGE];
   assign tw_addr_nxt = ADDR_W'(k_lo << (STAGE - 1));

`ifdef TW_ROM_PWR_SAVE_EN
   assign tw_en_nxt = issue && !sel_bf_nxt && (tw_addr_nxt != '0);
`else
   assign tw_en_nxt = issue;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pending    <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_RUN;
                  cnt   <= cnt + SIZE'(1);
               end
            end
            S_RUN: begin
               if (bus.flush_req)
                  flush_pend <= 1'b1;
               if (at_boundary) begin
                  if (pending) begin
                     state <= S_FLUSH;
                  end else begin
                     state      <= S_IDLE;
                     cnt        <= '0;
                     flush_pend <= 1'b0;
                  end
               end else if (accept) begin
                  cnt <= cnt + SIZE'(1);
                  if (cnt[SIZE-STAGE])
                     pending <= 1'b1;
                  else if (k == SIZE'(D - 1))
                     pending <= 1'b0;
               end
            end
            S_FLUSH: begin
               if (last_pseudo) begin
                  state      <= S_IDLE;
                  cnt        <= '0;
                  pending    <= 1'b0;
                  flush_pend <= 1'b0;
               end else begin
                  cnt <= cnt + SIZE'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Phase and address hold through gaps; the ROM-valid pipeline follows tw_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_bf_q      <= 1'b0;
         stage_valid_q <= 1'b0;
         tw_addr_q     <= '0;
         tw_en_q       <= 1'b0;
         tw_valid_q    <= 1'b0;
         tw_trivial_q  <= 1'b0;
         frame_last_q  <= 1'b0;
      end else begin
         stage_valid_q <= issue;
         frame_last_q  <= issue && (cnt == SIZE'(N - 1));
         tw_en_q       <= tw_en_nxt;
         tw_valid_q    <= tw_en_q;
         tw_trivial_q  <= stage_valid_q && (tw_addr_q == '0);
         if (issue) begin
            sel_bf_q  <= sel_bf_nxt;
            tw_addr_q <= tw_addr_nxt;
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.sel_bf      = sel_bf_q;
   assign bus.stage_valid = stage_valid_q;
   assign bus.tw_addr     = tw_addr_q;
   assign bus.tw_en       = tw_en_q;
   assign bus.tw_valid    = tw_valid_q;
   assign bus.tw_trivial  = tw_trivial_q;
   assign bus.frame_last  = frame_last_q;
   assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_fft_sdf_stage_tw_ctrl.sv
// Self-checking bench for fft_sdf_stage_tw_ctrl: sample-index model checked every cycle
// plus directed literal expectations (full frame, gap, flush, idle flush, reset mid-flush).
module tb_fft_sdf_stage_tw_ctrl;
   localparam int N     = 256;
   localparam int SIZE  = 8;
   localparam int STAGE = 4;
   localparam int D     = N >> STAGE;
   localparam int AW    = SIZE - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fft_sdf_stage_tw_ctrl_if #(.ADDR_W(AW)) bus ();

   fft_sdf_stage_tw_ctrl #(.N(N), .SIZE(SIZE), .STAGE(STAGE), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   // Model: mode 0 idle, 1 running, 2 draining; m_idx is the next sample index.
   int m_mode = 0;
   int m_idx  = 0;
   bit m_fp   = 1'b0;
   bit m_pend = 1'b0;
   bit e_sv = 1'b0, e_sel = 1'b0, e_last = 1'b0, e_twen = 1'b0, e_twv = 1'b0, e_triv = 1'b0;
   int e_addr = 0;

   bit m_rdy, m_acc, m_pseudo, m_issue, m_sel, m_bound;
   int m_addr;

   always_comb begin
      m_bound  = (m_mode == 1) && m_fp && (m_idx % (2 * D) == 0);
      m_rdy    = (m_mode == 0) || ((m_mode == 1) && !m_bound);
      m_acc    = m_rdy && (bus.in_valid === 1'b1);
      m_pseudo = (m_mode == 2);
      m_issue  = m_acc || m_pseudo;
      m_sel    = m_acc && ((m_idx % (2 * D)) >= D);
      m_addr   = (m_idx % D) * (N / 2 / D);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0; m_idx <= 0; m_fp <= 1'b0; m_pend <= 1'b0;
         e_sv <= 1'b0; e_sel <= 1'b0; e_last <= 1'b0; e_twen <= 1'b0;
         e_twv <= 1'b0; e_triv <= 1'b0; e_addr <= 0;
      end else begin
         e_twv  <= e_twen;
         e_triv <= e_sv && (e_addr == 0);
         e_sv   <= m_issue;
         e_last <= m_issue && (m_idx == N - 1);
         if (m_issue) begin
            e_sel  <= m_sel;
            e_addr <= m_addr;
         end
`ifdef TW_ROM_PWR_SAVE_EN
         e_twen <= m_issue && !m_sel && (m_addr != 0);
`else
         e_twen <= m_issue;
`endif
         case (m_mode)
            0: if (m_acc) begin m_mode <= 1; m_idx <= m_idx + 1; end
            1: begin
               if (m_bound) begin
                  if (m_pend) m_mode <= 2;
                  else begin m_mode <= 0; m_idx <= 0; m_fp <= 1'b0; end
               end else begin
                  if (bus.flush_req === 1'b1) m_fp <= 1'b1;
                  if (m_acc) begin
                     m_idx <= (m_idx + 1) % N;
                     if (m_sel) m_pend <= 1'b1;
                     else if (m_idx % (2 * D) == D - 1) m_pend <= 1'b0;
                  end
               end
            end
            default: begin
               if (m_idx % (2 * D) == D - 1) begin
                  m_mode <= 0; m_idx <= 0; m_fp <= 1'b0; m_pend <= 1'b0;
               end else m_idx <= m_idx + 1;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready",    int'(bus.in_ready),    int'(m_rdy));
         chk("busy",        int'(bus.busy),        int'(m_mode != 0));
         chk("stage_valid", int'(bus.stage_valid), int'(e_sv));
         chk("sel_bf",      int'(bus.sel_bf),      int'(e_sel));
         chk("tw_addr",     int'(bus.tw_addr),     e_addr);
         chk("frame_last",  int'(bus.frame_last),  int'(e_last));
         chk("tw_en",       int'(bus.tw_en),       int'(e_twen));
         chk("tw_valid",    int'(bus.tw_valid),    int'(e_twv));
         chk("tw_trivial",  int'(bus.tw_trivial),  int'(e_triv));
      end
   end

   task automatic step(input int v, input int f);
      bus.in_valid  = (v != 0);
      bus.flush_req = (f != 0);
      @(negedge clk);
   endtask

   initial begin
      int cnt_last, cnt_en, acc_n, nrdy_n, sv_n, z;
      bit done;
      bus.in_valid  = 1'b0;
      bus.flush_req = 1'b0;

      #21;
      chk("rst_in_ready",    int'(bus.in_ready),    1);
      chk("rst_busy",        int'(bus.busy),        0);
      chk("rst_stage_valid", int'(bus.stage_valid), 0);
      chk("rst_tw_addr",     int'(bus.tw_addr),     0);
      chk("rst_tw_valid",    int'(bus.tw_valid),    0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Full frame, back to back.
      cnt_last = 0; cnt_en = 0;
      for (int i = 0; i < N; i++) begin
         step(1, 0);
         if (bus.frame_last === 1'b1) cnt_last++;
         if (i < 2 * D && bus.tw_en === 1'b1) cnt_en++;
         if (i == 15) begin
            chk("s15_sel", int'(bus.sel_bf), 0);
            chk("s15_addr", int'(bus.tw_addr), 120);
         end
         if (i == 17) begin
            chk("s17_sel", int'(bus.sel_bf), 1);
            chk("s17_addr", int'(bus.tw_addr), 8);
         end
         if (i == 255) begin
            chk("s255_last", int'(bus.frame_last), 1);
            chk("s255_addr", int'(bus.tw_addr), 120);
         end
      end
      chk("frame_last_count", cnt_last, 1);
`ifdef TW_ROM_PWR_SAVE_EN
      chk("tw_en_per_32", cnt_en, 15);
`else
      chk("tw_en_per_32", cnt_en, 32);
`endif

      // Second frame: gap of 3 cycles after sample 20.
      for (int i = 0; i <= 20; i++) step(1, 0);
      chk("gap_pre_addr", int'(bus.tw_addr), 32);
      for (int i = 0; i < 3; i++) begin
         step(0, 0);
         chk("gap_sv", int'(bus.stage_valid), 0);
         chk("gap_addr_hold", int'(bus.tw_addr), 32);
      end
      step(1, 0);
      chk("gap_resume_sv", int'(bus.stage_valid), 1);
      chk("gap_resume_addr", int'(bus.tw_addr), 40);
      for (int i = 22; i <= 39; i++) step(1, 0);

      // Flush requested with sample 40.
      acc_n = 0; nrdy_n = 0; sv_n = 0; done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         if (bus.in_ready === 1'b1) acc_n++; else nrdy_n++;
         step(1, (c == 0) ? 1 : 0);
         if (bus.stage_valid === 1'b1) sv_n++;
         if (bus.busy === 1'b0) done = 1'b1;
      end
      chk("flush_done", int'(done), 1);
      chk("flush_accepts", acc_n, 24);
      chk("flush_not_ready", nrdy_n, 17);
      chk("flush_issued", sv_n, 40);
      chk("flush_last_addr", int'(bus.tw_addr), 120);
      chk("flush_last_sel", int'(bus.sel_bf), 0);
      step(0, 0);
      chk("post_flush_ready", int'(bus.in_ready), 1);
      chk("post_flush_sv", int'(bus.stage_valid), 0);

      // flush_req while idle is ignored.
      step(0, 1);
      step(0, 0);
      step(0, 0);
      chk("idle_flush_busy", int'(bus.busy), 0);
      chk("idle_flush_ready", int'(bus.in_ready), 1);
      chk("idle_flush_sv", int'(bus.stage_valid), 0);

      // Reset in the middle of a drain.
      z = 0; done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         step(1, (c == 1) ? 1 : 0);
         if (bus.busy === 1'b1 && bus.in_ready === 1'b0) z++;
         if (z == 6) done = 1'b1;
      end
      chk("mid_flush_reached", int'(done), 1);
      chk("mid_flush_busy", int'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready",   int'(bus.in_ready),    1);
      chk("arst_busy",       int'(bus.busy),        0);
      chk("arst_sv",         int'(bus.stage_valid), 0);
      chk("arst_tw_addr",    int'(bus.tw_addr),     0);
      chk("arst_tw_en",      int'(bus.tw_en),       0);
      chk("arst_tw_valid",   int'(bus.tw_valid),    0);
      chk("arst_tw_trivial", int'(bus.tw_trivial),  0);
      bus.in_valid  = 1'b0;
      bus.flush_req = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      step(1, 0);
      chk("restart_sv", int'(bus.stage_valid), 1);
      chk("restart_addr0", int'(bus.tw_addr), 0);
      chk("restart_busy", int'(bus.busy), 1);
      step(1, 0);
      chk("restart_addr1", int'(bus.tw_addr), 8);
      step(0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
